mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential controller that shares the single memory-controller port between instruction fetch (stage 1) and data access (stage 4). It arbitrates requests with data priority plus an anti-starvation limit, and sequences one memory transaction at a time over a req/ack handshake. It converts stage-4 size/offset information into byte enables and lane-aligned data, and returns load data right-justified so stage 4 performs sign/zero extension on the low bits.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is waiting before fetch is forced to win (≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_if_req  in  1  fetch request; held until o_if_valid.
- i_if_addr  in  32  fetch address, word aligned; stable while requesting.
- o_if_data  out  32  fetched word; valid with o_if_valid.
- o_if_valid  out  1  one-cycle completion pulse.
- o_if_stall  out  1  i_if_req & ~o_if_valid.
- i_d_req  in  1  data request; held until o_d_valid.
- i_d_op  in  1  0 = load, 1 = store.
- i_d_size  in  2  00 byte, 01 half, 10 word (= func_3[1:0]); 11 is treated as word.
- i_d_addr  in  32  byte address.
- i_d_wdata  in  32  store data, value in the low bits.
- o_d_rdata  out  32  load data, right-justified, upper bits zero.
- o_d_valid  out  1  one-cycle completion pulse.
- o_d_err  out  1  misaligned access; qualified by o_d_valid.
- o_d_stall  out  1  i_d_req & ~o_d_valid.
- mem_req  out  1  transaction request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, with {i_d_addr[31:2],2'b00} for data.
- mem_be  out  4  byte enables; 4'b1111 for reads.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read word; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion from memory; may arrive in the same cycle as mem_req or later.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- **IDLE arbitration.** Eligible requests are i_if_req and i_d_req, each masked in any cycle where its own valid is high.
  - Data wins unless fetch is also pending and streak == STARVE_LIMIT.
  - Data grant while fetch is pending: streak increments (saturating). Fetch grant: streak clears.
  - Data grant with misaligned access goes directly to RESP with err=1 and makes no memory access. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise the grant registers mem_req=1, mem_addr, mem_we, mem_be and mem_wdata, and moves to BUSY_IF or BUSY_D.
- **Byte enables.**
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111; wdata unchanged.
  - Loads: mem_we=0 and be=1111.
- **BUSY_x.** mem_* outputs stay constant. On mem_ack:
  - Capture the response. Fetch captures the full word. Data loads capture (mem_rdata >> 8*addr[1:0]), masked to 8, 16 or 32 bits by size. Stores capture rdata = 0.
  - Drop mem_req and go to RESP.
- **RESP.** Exactly one of o_if_valid / o_d_valid is high for one cycle, with its data (and err for data). The state then returns to IDLE.
- Response data registers hold their value until the next completion on the same port.

## Timing
- All outputs are registered except the stall signals. Reset values:
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Both valid=0, err=0, rdata=0, if_data=0.
  - streak=0, state=IDLE.
- Zero-wait memory:
  - cycle 0: request high in IDLE.
  - cycle 1: mem_req high, ack high.
  - cycle 2: RESP, valid high.
  - cycle 3: IDLE. A new grant is possible here, so mem_req rises in cycle 4.
- W wait cycles add W cycles of latency.
- Misaligned data access: request in cycle 0, valid+err in cycle 1, mem_req never asserted.
- Simultaneous requests in IDLE: one is granted and the other stays stalled. The loser is granted in the IDLE cycle after the winner's RESP.
- mem_ack outside BUSY_x is ignored.
- rst high at any edge returns everything to reset values at that edge, including mid-transaction (mem_req drops; the pending response is discarded). The memory controller is reset on the same rst.
- Requesters deasserting req before valid is a protocol violation; behaviour is unspecified.

## Test plan
- **Zero-wait LW.** LW at addr 0x104, mem_rdata=0xDEADBEEF, ack in the same cycle -> mem_addr=0x104, be=1111, o_d_rdata=0xDEADBEEF, valid exactly 2 cycles after the request, o_d_stall high for cycles 0–1.
- **SB with wait state.** SB addr 0x203, wdata=0x000000A5, ack after 2 waits -> mem_we=1, be=1000, mem_wdata=0xA5A5A5A5, valid 4 cycles after the request. Then LH at 0x202 with mem_rdata=0x8001xxxx -> o_d_rdata=0x00008001.
- **Misaligned accesses.** LW at 0x106 and SH at 0x1 -> o_d_valid and o_d_err high 1 cycle after the request; mem_req stays 0.
- **Starvation limit.** Both ports request continuously with STARVE_LIMIT=4 and zero-wait memory -> grant order D,D,D,D,IF repeating; no fetch waits more than 4 data transactions.
- **Reset mid-transaction.** rst asserted while in BUSY_D with no ack yet -> next cycle mem_req=0, no valid pulse; a later ack is ignored; a subsequent fetch completes normally.
- **Back-to-back fetch.** Fetch held with a new address each valid, zero-wait memory -> one completion every 3 cycles, o_if_data matching each address's memory word.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Memory-controller port shared by instruction fetch and data access.
// The arbiter is the master; the memory controller is the slave.
interface mem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data: data-first arbitration with an
// anti-starvation streak, one req/ack transaction at a time, byte-lane handling.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_if_req,
    input  logic [31:0]   i_if_addr,
    output logic [31:0]   o_if_data,
    output logic          o_if_valid,
    output logic          o_if_stall,
    input  logic          i_d_req,
    input  logic          i_d_op,
    input  logic [1:0]    i_d_size,
    input  logic [31:0]   i_d_addr,
    input  logic [31:0]   i_d_wdata,
    output logic [31:0]   o_d_rdata,
    output logic          o_d_valid,
    output logic          o_d_err,
    output logic          o_d_stall,
    mem_arbiter_if.master mem
);
    // state   | meaning
    // IDLE    | arbitrate pending requests
    // BUSY_IF | fetch transaction outstanding on the memory port
    // BUSY_D  | data transaction outstanding on the memory port
    // RESP    | one-cycle completion pulse on the granted port
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [1:0]    d_off_q, d_off_d, d_size_q, d_size_d;
    logic [31:0]   if_data_q, if_data_d, d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;

    logic          if_elig, d_elig, grant_d, grant_if, misaligned;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata, ld_shift, ld_data;

    assign if_elig    = i_if_req & ~if_valid_q;
    assign d_elig     = i_d_req & ~d_valid_q;
    assign grant_d    = d_elig & ~(if_elig & (streak_q == STREAK_MAX));
    assign grant_if   = if_elig & ~grant_d;
    assign misaligned = (i_d_size == 2'b01) ? i_d_addr[0]
                                            : (i_d_size[1] & (i_d_addr[1:0] != 2'b00));

    // Store lanes follow the byte offset; loads always read the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_d_wdata;
        case (i_d_size)
            2'b00: begin
                st_be    = 4'b0001 << i_d_addr[1:0];
                st_wdata = {4{i_d_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = i_d_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{i_d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = mem.mem_rdata >> {d_off_q, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (d_size_q)
            2'b00:   ld_data = {24'b0, ld_shift[7:0]};
            2'b01:   ld_data = {16'b0, ld_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        d_off_d     = d_off_q;
        d_size_d    = d_size_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    if (if_elig && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
                    if (misaligned) begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'h0;
                        state_d   = RESP;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_d_op;
                        mem_addr_d  = {i_d_addr[31:2], 2'b00};
                        mem_be_d    = i_d_op ? st_be : 4'b1111;
                        mem_wdata_d = st_wdata;
                        d_off_d     = i_d_addr[1:0];
                        d_size_d    = i_d_size;
                        state_d     = BUSY_D;
                    end
                end else if (grant_if) begin
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_if_addr;
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = 32'h0;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem.mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_data_d  = mem.mem_rdata;
                    if_valid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            BUSY_D: begin
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    d_rdata_d = mem_we_q ? 32'h0 : ld_data;
                    d_err_d   = 1'b0;
                    d_valid_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            d_off_q     <= 2'b00;
            d_size_q    <= 2'b00;
            if_data_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            d_err_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            d_off_q     <= d_off_d;
            d_size_q    <= d_size_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign o_if_data     = if_data_q;
    assign o_if_valid    = if_valid_q;
    assign o_if_stall    = i_if_req & ~if_valid_q;
    assign o_d_rdata     = d_rdata_q;
    assign o_d_valid     = d_valid_q;
    assign o_d_err       = d_err_q;
    assign o_d_stall     = i_d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small wait-state memory model plus
// per-scenario tasks with hand-computed expectations.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'h0;
    logic [31:0] o_if_data;
    logic        o_if_valid, o_if_stall;
    logic        i_d_req = 1'b0;
    logic        i_d_op = 1'b0;
    logic [1:0]  i_d_size = 2'b00;
    logic [31:0] i_d_addr = 32'h0;
    logic [31:0] i_d_wdata = 32'h0;
    logic [31:0] o_d_rdata;
    logic        o_d_valid, o_d_err, o_d_stall;

    int checks = 0;
    int failures = 0;
    int mem_waits = 0;
    bit mem_mute = 1'b0;
    bit stray_ack = 1'b0;

    mem_arbiter_if mem();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_data(o_if_data),
        .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
        .i_d_req(i_d_req), .i_d_op(i_d_op), .i_d_size(i_d_size), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid),
        .o_d_err(o_d_err), .o_d_stall(o_d_stall),
        .mem(mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h104: mem_word = 32'hDEADBEEF;
            32'h200: mem_word = 32'h80011234;
            default: mem_word = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Memory: acks after mem_waits idle cycles, driven at the falling edge.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            if (stray_ack) begin
                mem.mem_ack = 1'b1;
                mem.mem_rdata = 32'hBAD0BAD0;
            end else if (rst || !mem.mem_req || mem_mute) begin
                mem.mem_ack = 1'b0;
                cnt = 0;
            end else if (cnt == mem_waits) begin
                mem.mem_ack = 1'b1;
                mem.mem_rdata = mem_word(mem.mem_addr);
                cnt = 0;
            end else begin
                mem.mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic run_d(input logic op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic saw_req,
                         output logic we, output logic [3:0] be, output logic [31:0] maddr,
                         output logic [31:0] mwd, output logic [31:0] rd, output logic err,
                         output int stalls);
        @(posedge clk); #1;
        i_d_req = 1'b1; i_d_op = op; i_d_size = sz; i_d_addr = a; i_d_wdata = wd;
        lat = -1; saw_req = 1'b0; we = 1'b0; be = 4'h0; maddr = 32'h0; mwd = 32'h0;
        rd = 32'h0; err = 1'b0; stalls = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (o_d_stall) stalls++;
            if (mem.mem_req && !saw_req) begin
                saw_req = 1'b1; we = mem.mem_we; be = mem.mem_be;
                maddr = mem.mem_addr; mwd = mem.mem_wdata;
            end
            if (o_d_valid) begin
                lat = k; rd = o_d_rdata; err = o_d_err;
            end
        end
        @(posedge clk); #1;
        i_d_req = 1'b0;
    endtask

    task automatic run_if(input logic [31:0] a, output int lat, output logic [31:0] data);
        @(posedge clk); #1;
        i_if_req = 1'b1; i_if_addr = a;
        lat = -1; data = 32'h0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (o_if_valid) begin
                lat = k; data = o_if_data;
            end
        end
        @(posedge clk); #1;
        i_if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", mem.mem_req); end
        checks++; if (mem.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", mem.mem_we); end
        checks++; if (mem.mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be: got %h expected 0", mem.mem_be); end
        checks++; if (mem.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem.mem_addr); end
        checks++; if (mem.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h expected 0", mem.mem_wdata); end
        checks++; if (o_if_valid !== 1'b0 || o_d_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got if=%b d=%b expected 0", o_if_valid, o_d_valid); end
        checks++; if (o_d_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_d_err); end
        checks++; if (o_d_rdata !== 32'h0 || o_if_data !== 32'h0) begin failures++; $display("FAIL reset_data: got rd=%h if=%h expected 0", o_d_rdata, o_if_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_wait_lw();
        int lat, stalls; logic saw, we, err; logic [3:0] be; logic [31:0] ma, mwd, rd;
        mem_waits = 0;
        run_d(1'b0, 2'b10, 32'h104, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (ma !== 32'h104 || be !== 4'hF || we !== 1'b0) begin failures++; $display("FAIL lw_bus: got addr=%h be=%h we=%b expected 104 f 0", ma, be, we); end
        checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL lw_rdata: got %h err=%b expected deadbeef err=0", rd, err); end
        checks++; if (stalls !== 2) begin failures++; $display("FAIL lw_stall_cycles: got %0d expected 2", stalls); end
    endtask

    task automatic test_store_and_lanes();
        int lat, stalls; logic saw, we, err; logic [3:0] be; logic [31:0] ma, mwd, rd;
        mem_waits = 2;
        run_d(1'b1, 2'b00, 32'h203, 32'h000000A5, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sb_latency: got %0d expected 4", lat); end
        checks++; if (we !== 1'b1 || be !== 4'b1000 || ma !== 32'h200) begin failures++; $display("FAIL sb_bus: got we=%b be=%b addr=%h expected 1 1000 200", we, be, ma); end
        checks++; if (mwd !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", mwd); end
        mem_waits = 0;
        run_d(1'b0, 2'b01, 32'h202, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (rd !== 32'h00008001 || be !== 4'hF || ma !== 32'h200) begin failures++; $display("FAIL lh_rdata: got %h be=%h addr=%h expected 00008001 f 200", rd, be, ma); end
        run_d(1'b0, 2'b00, 32'h201, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (rd !== 32'h00000012) begin failures++; $display("FAIL lb_rdata: got %h expected 00000012", rd); end
        mem_waits = 1;
        run_d(1'b1, 2'b01, 32'h102, 32'hBEEFCAFE, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (lat !== 3 || be !== 4'b1100 || mwd !== 32'hCAFECAFE) begin failures++; $display("FAIL sh_upper: got lat=%0d be=%b wdata=%h expected 3 1100 cafecafe", lat, be, mwd); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sh_rdata_zero: got %h expected 0", rd); end
        mem_waits = 0;
        run_d(1'b1, 2'b01, 32'h100, 32'h00001234, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (be !== 4'b0011 || mwd !== 32'h12341234) begin failures++; $display("FAIL sh_lower: got be=%b wdata=%h expected 0011 12341234", be, mwd); end
    endtask

    task automatic test_misaligned();
        int lat, stalls; logic saw, we, err; logic [3:0] be; logic [31:0] ma, mwd, rd;
        run_d(1'b0, 2'b10, 32'h106, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (lat !== 1 || err !== 1'b1 || saw !== 1'b0) begin failures++; $display("FAIL lw_misaligned: got lat=%0d err=%b memreq=%b expected 1 1 0", lat, err, saw); end
        run_d(1'b1, 2'b01, 32'h001, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (lat !== 1 || err !== 1'b1 || saw !== 1'b0) begin failures++; $display("FAIL sh_misaligned: got lat=%0d err=%b memreq=%b expected 1 1 0", lat, err, saw); end
        run_d(1'b0, 2'b10, 32'h104, 32'h0, lat, saw, we, be, ma, mwd, rd, err, stalls);
        checks++; if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_clears: got err=%b rd=%h expected 0 deadbeef", err, rd); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses, reqs; logic [31:0] data;
        mem_mute = 1'b1;
        @(posedge clk); #1;
        i_d_req = 1'b1; i_d_op = 1'b0; i_d_size = 2'b10; i_d_addr = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem.mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy: got mem_req=%b expected 1", mem.mem_req); end
        @(posedge clk); #1;
        rst = 1'b1; i_d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem.mem_req !== 1'b0 || o_d_valid !== 1'b0) begin failures++; $display("FAIL rstmid_drop: got mem_req=%b valid=%b expected 0 0", mem.mem_req, o_d_valid); end
        @(posedge clk); #1;
        stray_ack = 1'b1;
        pulses = 0; reqs = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_d_valid || o_if_valid) pulses++;
            if (mem.mem_req) reqs++;
            @(posedge clk); #1;
            stray_ack = 1'b0;
        end
        checks++; if (pulses !== 0 || reqs !== 0) begin failures++; $display("FAIL stray_ack: got pulses=%0d reqs=%0d expected 0 0", pulses, reqs); end
        mem_mute = 1'b0;
        run_if(32'h400, lat, data);
        checks++; if (lat !== 2 || data !== 32'h0400FBFF) begin failures++; $display("FAIL rstmid_fetch: got lat=%0d data=%h expected 2 0400fbff", lat, data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int t [4];
        int n;
        addrs[0] = 32'h500; addrs[1] = 32'h504; addrs[2] = 32'h508; addrs[3] = 32'h50C;
        n = 0;
        @(posedge clk); #1;
        i_if_req = 1'b1; i_if_addr = addrs[0];
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (o_if_valid) begin
                checks++; if (o_if_data !== mem_word(addrs[n])) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", n, o_if_data, mem_word(addrs[n])); end
                t[n] = k;
                n++;
            end
            @(posedge clk); #1;
            if (n < 4) i_if_addr = addrs[n]; else i_if_req = 1'b0;
        end
        i_if_req = 1'b0;
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", n); end
        else begin
            checks++; if (t[0] !== 2) begin failures++; $display("FAIL b2b_first: got %0d expected 2", t[0]); end
            for (int i = 1; i < 4; i++) begin
                checks++; if (t[i] - t[i-1] !== 3) begin failures++; $display("FAIL b2b_period%0d: got %0d expected 3", i, t[i] - t[i-1]); end
            end
        end
    endtask

    task automatic test_starvation();
        bit is_if [10];
        int tg [10];
        int n;
        logic prev;
        n = 0; prev = 1'b0;
        mem_waits = 0;
        @(posedge clk); #1;
        i_if_req = 1'b1; i_if_addr = 32'h1000;
        i_d_req = 1'b1; i_d_op = 1'b0; i_d_size = 2'b10; i_d_addr = 32'h2000;
        for (int k = 0; k < 80 && n < 10; k++) begin
            @(negedge clk);
            if (mem.mem_req && !prev) begin
                is_if[n] = (mem.mem_addr == 32'h1000);
                tg[n] = k;
                n++;
            end
            prev = mem.mem_req;
            @(posedge clk); #1;
        end
        i_if_req = 1'b0; i_d_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (n !== 10) begin failures++; $display("FAIL starve_count: got %0d expected 10", n); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (is_if[i] !== (i == 4 || i == 9)) begin failures++; $display("FAIL starve_order%0d: got is_fetch=%b expected %b", i, is_if[i], (i == 4 || i == 9)); end
                if (i > 0) begin
                    checks++; if (tg[i] - tg[i-1] !== 3) begin failures++; $display("FAIL starve_gap%0d: got %0d expected 3", i, tg[i] - tg[i-1]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_store_and_lanes();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_starvation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
